// File: rtl/xilinx_primitive_pkg.sv
// Shared types and sizing helpers for the single-port BRAM controller.
package xilinx_primitive_pkg;

  // Controller states; INIT is only reachable when memory clearing is built in.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  // Number of byte-lane write enables the BRAM primitive exposes for a data width.
  function automatic int we_width(input int data_width);
    if (data_width > 36)      return 8;
    else if (data_width > 18) return 4;
    else if (data_width > 9)  return 2;
    else                      return 1;
  endfunction

  // Read latency in cycles, including the optional BRAM output register.
  function automatic int read_latency(input int do_reg);
    return (do_reg != 0) ? 2 : 1;
  endfunction

endpackage

// File: rtl/xilinx_sp_bram_rsp_fifo.sv
// First-word-fall-through response buffer. Push and pop may happen in the
// same cycle, including when full (slot is read out and rewritten on the same
// edge) or empty (pop is ignored, push lands).
module xilinx_sp_bram_rsp_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/xilinx_sp_bram_ctrl.sv
// Request/response front end for a single-port Xilinx BRAM primitive.
// Reads return in order through a credit-managed response buffer, so the
// buffer can never overflow even with rsp_ready held low.
// Build option: XILINX_SP_BRAM_CTRL_INIT_EN adds an INIT phase after reset
// that writes zero to every word before requests are accepted.
module xilinx_sp_bram_ctrl
  import xilinx_primitive_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 10,
  parameter  int DO_REG     = 0,
  parameter  int RSP_DEPTH  = 4,
  localparam int WE_W       = we_width(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [WE_W-1:0]       req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  bram_en,
  output logic                  bram_regce,
  output logic                  bram_rst,
  output logic [14:0]           bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  output logic [7:0]            bram_we,
  input  logic [DATA_WIDTH-1:0] bram_do
);

  localparam int LAT   = read_latency(DO_REG);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

`ifdef XILINX_SP_BRAM_CTRL_INIT_EN
  localparam ctrl_state_e RESET_STATE = INIT;
`else
  localparam ctrl_state_e RESET_STATE = RUN;
`endif

  ctrl_state_e      state;
  ctrl_state_e      state_next;
  logic             accept;
  logic             rd_accept;
  logic [LAT-1:0]   rd_pipe;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] used;
  logic [CNT_W-1:0] credit;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             rsp_pop;

  assign bram_regce = 1'b1;
  assign bram_rst   = 1'b0;

  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;

`ifdef XILINX_SP_BRAM_CTRL_INIT_EN
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  init_last;

  assign init_last = (init_addr == '1);

  // Walk every word address once while clearing memory
  always_ff @(posedge CLK) begin
    if (RST)                init_addr <= '0;
    else if (state == INIT) init_addr <= init_addr + 1'b1;
  end
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= RESET_STATE;
    else     state <= state_next;
  end

  // Next-state: leave INIT after the last address has been written
  always_comb begin
    state_next = state;
`ifdef XILINX_SP_BRAM_CTRL_INIT_EN
    if (state == INIT && init_last) state_next = RUN;
`else
    state_next = RUN;
`endif
  end

  // BRAM port drive: clear sweep in INIT, otherwise pass accepted requests through
  always_comb begin
    bram_en   = 1'b0;
    bram_we   = '0;
    bram_addr = '0;
    bram_di   = '0;
    if (!RST) begin
`ifdef XILINX_SP_BRAM_CTRL_INIT_EN
      if (state == INIT) begin
        bram_en   = 1'b1;
        bram_we   = 8'({WE_W{1'b1}});
        bram_addr = 15'(init_addr);
      end else
`endif
      if (accept) begin
        bram_en   = 1'b1;
        bram_addr = 15'(req_addr);
        bram_di   = req_wdata;
        if (req_we) bram_we = 8'(req_be);
      end
    end
  end

  // Read tokens travel alongside the BRAM pipeline; the oldest one marks valid bram_do
  always_ff @(posedge CLK) begin
    if (RST) rd_pipe <= '0;
    else     rd_pipe <= LAT'({rd_pipe, rd_accept});
  end

  // Count reads still inside the BRAM pipeline
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CNT_W'(rd_pipe[i]);
  end

  // Credit covers both buffered and in-flight reads; the full term is implied
  // by credit but keeps the buffer safe if RSP_DEPTH is ever misconfigured.
  assign used      = fifo_count + inflight;
  assign credit    = CNT_W'(RSP_DEPTH) - used;
  assign req_ready = !RST && (state == RUN) && (credit != '0) && !fifo_full;

  assign rsp_valid = !RST && !fifo_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;

  xilinx_sp_bram_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (rd_pipe[LAT-1]),
    .push_data (bram_do),
    .pop       (rsp_pop),
    .pop_data  (rsp_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_xilinx_sp_bram_ctrl.sv
// Bench for xilinx_sp_bram_ctrl: two instances (DO_REG=0 and DO_REG=1), each
// backed by a behavioural BRAM. Expected read data comes from a plain word
// array updated with byte masks on every accepted write.
module tb_xilinx_sp_bram_ctrl;

  logic CLK;
  logic RST;

  logic        req_valid [2];
  logic        req_we    [2];
  logic [3:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_ready [2];

  wire         req_ready  [2];
  wire         rsp_valid  [2];
  wire  [31:0] rsp_rdata  [2];
  wire         bram_en    [2];
  wire         bram_regce [2];
  wire         bram_rst   [2];
  wire  [14:0] bram_addr  [2];
  wire  [31:0] bram_di    [2];
  wire  [7:0]  bram_we    [2];
  wire  [31:0] bram_do    [2];

`ifdef XILINX_SP_BRAM_CTRL_INIT_EN
  localparam int INIT_CYC = 16;
`else
  localparam int INIT_CYC = 0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_ref [2][16];
  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];
  logic        acc_now  [2];
  logic        vld_seen [2];
  logic        en_seen  [2];
  logic [7:0]  we_seen  [2];
  logic [14:0] snap_addr [2];
  logic [31:0] snap_di   [2];
  logic [7:0]  snap_we   [2];
  logic [31:0] last_rsp  [2];
  int          pop_cnt   [2];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  xilinx_sp_bram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DO_REG(0), .RSP_DEPTH(4)) u_dut0 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .bram_en(bram_en[0]), .bram_regce(bram_regce[0]), .bram_rst(bram_rst[0]),
    .bram_addr(bram_addr[0]), .bram_di(bram_di[0]), .bram_we(bram_we[0]), .bram_do(bram_do[0])
  );

  xilinx_sp_bram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DO_REG(1), .RSP_DEPTH(4)) u_dut1 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .bram_en(bram_en[1]), .bram_regce(bram_regce[1]), .bram_rst(bram_rst[1]),
    .bram_addr(bram_addr[1]), .bram_di(bram_di[1]), .bram_we(bram_we[1]), .bram_do(bram_do[1])
  );

  // Behavioural BRAM per instance: read-first latch, optional output register
  for (genvar k = 0; k < 2; k++) begin : g_bram
    logic [31:0] mem [16];
    logic [31:0] q0;
    logic [31:0] q1;
    logic        loaded = 1'b0;
    always @(posedge CLK) begin
      if (!loaded) begin
        for (int a = 0; a < 16; a++) mem[a] <= 32'hA5A5_0000 | a;
        loaded <= 1'b1;
      end else if (bram_en[k]) begin
        q0 <= mem[bram_addr[k][3:0]];
        for (int b = 0; b < 4; b++)
          if (bram_we[k][b]) mem[bram_addr[k][3:0]][b*8 +: 8] <= bram_di[k][b*8 +: 8];
      end
      if (bram_regce[k]) q1 <= q0;
    end
    assign bram_do[k] = (k == 0) ? q0 : q1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_size(input int k);
    return (k == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic void exp_push(input int k, input logic [31:0] d);
    if (k == 0) exp0.push_back(d);
    else        exp1.push_back(d);
  endfunction

  function automatic logic [31:0] exp_pop(input int k);
    if (k == 0) return exp0.pop_front();
    else        return exp1.pop_front();
  endfunction

  // One clock: sample at negedge (model + checks), return #1 after posedge
  task automatic cyc();
    logic [31:0] mask;
    logic [31:0] e;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      acc_now[k]  = 1'b0;
      vld_seen[k] = rsp_valid[k];
      en_seen[k]  = bram_en[k];
      we_seen[k]  = bram_we[k];
      if (RST) begin
        if (k == 0) exp0.delete();
        else        exp1.delete();
`ifdef XILINX_SP_BRAM_CTRL_INIT_EN
        for (int a = 0; a < 16; a++) mem_ref[k][a] = '0;
`endif
        chk($sformatf("rst_rsp_valid_k%0d", k), rsp_valid[k], 1'b0);
        chk($sformatf("rst_req_ready_k%0d", k), req_ready[k], 1'b0);
        chk($sformatf("rst_bram_en_k%0d", k), bram_en[k], 1'b0);
        chk($sformatf("rst_bram_we_k%0d", k), bram_we[k], 8'h00);
        chk($sformatf("regce_rst_k%0d", k), {bram_regce[k], bram_rst[k]}, 2'b10);
      end else begin
        if (rsp_valid[k] && rsp_ready[k]) begin
          chk($sformatf("rsp_expected_k%0d", k), exp_size(k) != 0, 1'b1);
          if (exp_size(k) != 0) begin
            e = exp_pop(k);
            chk($sformatf("rsp_data_k%0d", k), rsp_rdata[k], e);
          end
          last_rsp[k] = rsp_rdata[k];
          pop_cnt[k]++;
        end
        if (req_valid[k] && req_ready[k]) begin
          acc_now[k]   = 1'b1;
          snap_addr[k] = bram_addr[k];
          snap_di[k]   = bram_di[k];
          snap_we[k]   = bram_we[k];
          if (req_we[k]) begin
            mask = '0;
            for (int b = 0; b < 4; b++) if (req_be[k][b]) mask[b*8 +: 8] = 8'hFF;
            mem_ref[k][req_addr[k]] = (mem_ref[k][req_addr[k]] & ~mask) | (req_wdata[k] & mask);
          end else begin
            exp_push(k, mem_ref[k][req_addr[k]]);
          end
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_req(input int k, input logic we, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] be, output int waited);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_be[k]    = be;
    waited = 0;
    cyc();
    while (!acc_now[k] && waited < 100) begin
      waited++;
      cyc();
    end
    chk($sformatf("req_accepted_k%0d", k), acc_now[k], 1'b1);
    req_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k, output int n);
    n = 0;
    while (exp_size(k) != 0 && n < 50) begin
      cyc();
      n++;
    end
    chk($sformatf("drain_empty_k%0d", k), exp_size(k), 0);
  endtask

  initial begin
    int w;
    int n;
    int acc;
    int stall;
    int p0;
    logic [31:0] exp3;

    RST = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0;   req_be[k] = '0;   rsp_ready[k] = 1'b0;
      pop_cnt[k] = 0;      last_rsp[k] = '0;
      for (int a = 0; a < 16; a++) mem_ref[k][a] = 32'hA5A5_0000 | a;
    end
    repeat (3) cyc();
    RST = 1'b0;

    // Cycles from reset release until requests are taken
    n = 0;
    @(negedge CLK);
`ifdef XILINX_SP_BRAM_CTRL_INIT_EN
    chk("init_bram_we", bram_we[0], 8'h0F);
`else
    chk("idle_bram_en", bram_en[0], 1'b0);
`endif
    while (!req_ready[0] && n < 100) begin
      n++;
      @(negedge CLK);
    end
    chk("ready_after_reset_cycles", n, INIT_CYC);
    chk("ready_after_reset_k1", req_ready[1], 1'b1);
    @(posedge CLK);
    #1;

`ifdef XILINX_SP_BRAM_CTRL_INIT_EN
    exp3 = 32'h0;
`else
    exp3 = 32'hA5A5_0003;
`endif

    for (int k = 0; k < 2; k++) begin
      rsp_ready[k] = 1'b1;

      // Contents after reset
      do_req(k, 1'b0, 4'd3, '0, '0, w);
      drain(k, n);
      chk($sformatf("addr3_after_reset_k%0d", k), last_rsp[k], exp3);

      // Write then immediate read of the same word, with read latency
      do_req(k, 1'b1, 4'd5, 32'hDEAD_BEEF, 4'hF, w);
      chk($sformatf("wr_bram_port_k%0d", k), {snap_addr[k], snap_di[k], snap_we[k]},
          {15'd5, 32'hDEAD_BEEF, 8'h0F});
      do_req(k, 1'b0, 4'd5, '0, '0, w);
      chk($sformatf("rd_bram_port_k%0d", k), {snap_addr[k], snap_we[k]}, {15'd5, 8'h00});
      n = 0;
      do begin
        cyc();
        n++;
      end while (!vld_seen[k] && n < 20);
      chk($sformatf("rd_latency_k%0d", k), n, k + 2);
      chk($sformatf("rd_data_addr5_k%0d", k), last_rsp[k], 32'hDEAD_BEEF);
      cyc();
      chk($sformatf("idle_bram_k%0d", k), {en_seen[k], we_seen[k]}, 9'h000);

      // Partial byte-lane write
      do_req(k, 1'b1, 4'd7, 32'hAAAA_AAAA, 4'hF, w);
      do_req(k, 1'b1, 4'd7, 32'h1122_3344, 4'h3, w);
      do_req(k, 1'b0, 4'd7, '0, '0, w);
      drain(k, n);
      chk($sformatf("be_merge_addr7_k%0d", k), last_rsp[k], 32'hAAAA_3344);

      // Reset while reads are buffered and in flight
      rsp_ready[k] = 1'b0;
      do_req(k, 1'b0, 4'd1, '0, '0, w);
      do_req(k, 1'b0, 4'd2, '0, '0, w);
      repeat (3) cyc();
      do_req(k, 1'b0, 4'd3, '0, '0, w);
      do_req(k, 1'b0, 4'd4, '0, '0, w);
      RST = 1'b1;
      cyc();
      RST = 1'b0;
      rsp_ready[k] = 1'b1;
      for (int i = 0; i < 10; i++) begin
        cyc();
        chk($sformatf("no_stale_rsp_k%0d_c%0d", k, i), vld_seen[k], 1'b0);
      end

      // Credit limit with the response side stalled
      p0 = pop_cnt[k];
      rsp_ready[k] = 1'b0;
      acc = 0;
      req_valid[k] = 1'b1;
      req_we[k]    = 1'b0;
      req_addr[k]  = 4'd0;
      for (int i = 0; i < 8 + INIT_CYC; i++) begin
        cyc();
        if (acc_now[k]) begin
          acc++;
          req_addr[k] = 4'(acc);
        end
      end
      chk($sformatf("stalled_accepts_k%0d", k), acc, 4);
      chk($sformatf("stalled_ready_k%0d", k), req_ready[k], 1'b0);
      rsp_ready[k] = 1'b1;
      n = 0;
      while (acc < 6 && n < 50) begin
        cyc();
        n++;
        if (acc_now[k]) begin
          acc++;
          req_addr[k] = 4'(acc);
        end
      end
      req_valid[k] = 1'b0;
      chk($sformatf("resumed_accepts_k%0d", k), acc, 6);
      drain(k, n);
      chk($sformatf("stalled_rsp_count_k%0d", k), pop_cnt[k] - p0, 6);

      // Random fill, then back-to-back random reads at full rate
      for (int a = 0; a < 16; a++)
        do_req(k, 1'b1, 4'(a), $urandom, 4'($urandom_range(0, 15)), w);
      p0 = pop_cnt[k];
      stall = 0;
      for (int i = 0; i < 40; i++) begin
        do_req(k, 1'b0, 4'($urandom_range(0, 15)), '0, '0, w);
        stall += w;
      end
      chk($sformatf("stream_stalls_k%0d", k), stall, 0);
      drain(k, n);
      chk($sformatf("stream_tail_k%0d", k), n, k + 2);
      chk($sformatf("stream_rsp_count_k%0d", k), pop_cnt[k] - p0, 40);
    end

    repeat (5) cyc();
    chk("final_queue_k0", exp_size(0), 0);
    chk("final_queue_k1", exp_size(1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xilinx_sp_bram_ctrl.md
XILINX_SP_BRAM_CTRL -- requirements
Module: xilinx_sp_bram_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: request/response data width, 1-72.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: word address width, 1-15.
REQ-003 SHALL have parameter DO_REG, default 0: matches the downstream BRAM output-register setting; read latency LAT = 1+DO_REG.
REQ-004 SHALL have parameter RSP_DEPTH, default 4: response buffer entries; must be >= LAT+1.
REQ-005 SHALL have one clock and a synchronous, active-high reset: ports CLK (input, 1) and RST (input, 1).
REQ-006 SHALL have the request ports: req_valid in 1; req_ready out 1; req_we in 1 (1=write, 0=read); req_addr in ADDR_WIDTH; req_wdata in DATA_WIDTH; req_be in WE_W (byte-lane enable).
REQ-007 SHALL have the response ports: rsp_valid out 1; rsp_ready in 1; rsp_rdata out DATA_WIDTH.
REQ-008 SHALL have the BRAM-side ports: bram_en out 1; bram_regce out 1; bram_rst out 1; bram_addr out 15; bram_di out DATA_WIDTH; bram_we out 8; bram_do in DATA_WIDTH.

Function
REQ-009 SHALL set WE_W to 8 for DATA_WIDTH 37-72, 4 for 19-36, 2 for 10-18, and 1 for 1-9.
REQ-010 SHALL treat a request as accepted when req_valid && req_ready on a rising CLK edge.
REQ-011 SHALL, in the accept cycle, drive the BRAM combinationally: bram_en=1, bram_addr=zero-extended req_addr, bram_di=req_wdata, bram_we=zero-extended (req_we ? req_be : 0).
REQ-012 SHALL drive bram_en=0 and bram_we=0 when no request is accepted and the block is not in INIT.
REQ-013 SHALL tie bram_regce to 1 and bram_rst to 0.
REQ-014 SHALL make a write produce no response.
REQ-015 SHALL make an accepted read push bram_do into the response buffer exactly LAT cycles later, using a LAT-deep valid shift register.
REQ-016 SHALL keep credit = RSP_DEPTH - (buffer occupancy + reads in flight).
REQ-017 SHALL compute req_ready = (state==RUN) && (credit>0), independent of req_we and req_valid; the buffer never overflows.
REQ-018 SHALL present the response buffer first-word-fall-through: rsp_valid = not empty, rsp_rdata = head entry, pop on rsp_valid && rsp_ready.
REQ-019 SHALL allow a push and a pop in the same cycle, including when the buffer is full or empty, without loss or duplication.
REQ-020 SHALL return responses in request order; a read accepted the cycle after a write to the same address returns the written data.
REQ-021 SHALL sustain 1 request/cycle when rsp_ready is held at 1.

Reset
REQ-022 SHALL, while RST=1, set rsp_valid=0, req_ready=0, bram_en=0, bram_we=0, buffer empty, in-flight valids cleared, credit=RSP_DEPTH.
REQ-023 SHALL, on RST asserted mid-operation, discard all in-flight reads and buffered responses; no stale response appears after reset.
REQ-024 SHALL enter RUN on the first cycle after RST deasserts when XILINX_SP_BRAM_CTRL_INIT_EN is undefined.

Configuration
REQ-025 SHALL, with XILINX_SP_BRAM_CTRL_INIT_EN defined, enter state INIT after reset and write 0 to addresses 0..2**ADDR_WIDTH-1, one per cycle (bram_en=1, bram_we=all WE_W bits set, bram_di=0), with req_ready=0 throughout, then enter RUN the cycle after the last address.
REQ-026 SHALL, with XILINX_SP_BRAM_CTRL_INIT_EN undefined, contain no INIT state or address counter; memory contents after reset are whatever the BRAM init provides.

Structure
REQ-027 SHALL place the state enum (INIT, RUN), the WE-width function and the read-latency function in xilinx_primitive_pkg.
REQ-028 SHALL implement the response buffer as sub-module xilinx_sp_bram_rsp_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-029 SHALL cover: DO_REG=0; write addr 5 data 0xDEADBEEF be=0xF, then read addr 5 -> rsp_rdata=0xDEADBEEF, bram_do sampled 1 cycle after the read is accepted.
REQ-030 SHALL cover: DO_REG=1, rsp_ready=0, 6 back-to-back reads -> exactly 4 accepted, req_ready=0 afterward; raise rsp_ready -> 4 responses in order, then remaining 2 accepted.
REQ-031 SHALL cover: write 0x11223344 be=0x3 over 0xAAAAAAAA at addr 7, then read addr 7 -> 0xAAAA3344.
REQ-032 SHALL cover: RST pulsed for 1 cycle with 2 reads in flight and 2 buffered -> rsp_valid=0 after reset; no response within the next 10 cycles.
REQ-033 SHALL cover: INIT_EN defined, ADDR_WIDTH=4 -> req_ready=0 for 16 cycles after reset; read addr 3 returns 0.
REQ-034 SHALL cover: continuous random reads with rsp_ready=1 -> 1 response/cycle, order preserved versus a scoreboard.
